// File: rtl/fa8b_rev_pkg.sv
// Shared types and constants for the reversible dual-rail adder sequencer.
package fa8b_rev_pkg;

  localparam int unsigned W     = 8;
  localparam int unsigned CNT_W = 8;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    FWD  = 3'd1,
    CAP  = 3'd2,
    BWD  = 3'd3,
    NUL  = 3'd4
  } state_t;

  // One dual-rail bit: t is the true rail, n the complement rail.
  typedef struct packed {
    logic t;
    logic n;
  } dr_t;

  localparam dr_t DR_NULL = '{t: 1'b0, n: 1'b0};
  localparam dr_t DR_ONE  = '{t: 1'b1, n: 1'b0};
  localparam dr_t DR_ZERO = '{t: 1'b0, n: 1'b1};

  function automatic dr_t dr_bit(input logic en, input logic d);
    dr_t r;
    r = DR_NULL;
    if (en) r = d ? DR_ONE : DR_ZERO;
    return r;
  endfunction

endpackage

// File: rtl/dr_enc8.sv
// Binary-to-dual-rail encoder; a deasserted enable yields the null spacer on every pair.
module dr_enc8
  import fa8b_rev_pkg::*;
(
  input  logic         i_en,
  input  logic [W-1:0] i_d,
  output logic [W-1:0] o_t_c,
  output logic [W-1:0] o_n_c
);

  assign o_t_c = i_en ? i_d  : '0;
  assign o_n_c = i_en ? ~i_d : '0;

endmodule

// File: rtl/fa8b_rev_seq.sv
// Four-phase sequencer (forward, capture, backward, null) feeding the reversible 8-bit
// dual-rail adder macro, with operand and result valid/ready handshakes.
module fa8b_rev_seq
  import fa8b_rev_pkg::*;
#(
  parameter int unsigned SETTLE_CYC = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         op_valid,
  output logic         op_ready,
  input  logic [W-1:0] op_a,
  input  logic [W-1:0] op_b,
  input  logic         op_cin,
  output logic [W-1:0] a_f,
  output logic [W-1:0] a_not_f,
  output logic [W-1:0] a_b,
  output logic [W-1:0] a_not_b,
  output logic [W-1:0] b,
  output logic [W-1:0] b_not,
  output logic         c0_f,
  output logic         c0_f_not,
  output logic         c0_b,
  output logic         c0_not_b,
  input  logic [W-1:0] s,
  input  logic [W-1:0] s_not,
  input  logic         c7,
  input  logic         c7_not,
  output logic         res_valid,
  input  logic         res_ready,
  output logic [W-1:0] res_sum,
  output logic         res_cout,
  output logic         res_err
);

  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(SETTLE_CYC - 1);

  state_t           r_state, w_state_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic [W-1:0]     r_a, r_b, w_a_nxt, w_b_nxt;
  logic             r_cin, w_cin_nxt;
  logic             r_idle;
  logic             w_accept, w_cap, w_done;
  logic             w_fwd_en, w_b_en, w_bwd_en;
  logic             w_rail_err;
  logic [W-1:0]     w_af_t, w_af_n, w_ab_t, w_ab_n, w_b_t, w_b_n;
  dr_t              w_c0f, w_c0b;

  // r_idle is low through reset so op_ready stays low until the first clock after release.
  assign op_ready   = r_idle && (!res_valid || res_ready);
  assign w_accept   = op_valid && op_ready;
  assign w_rail_err = (|(s ~^ s_not)) || (c7 ~^ c7_not);

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_cap       = 1'b0;
    w_done      = 1'b0;
    w_a_nxt     = r_a;
    w_b_nxt     = r_b;
    w_cin_nxt   = r_cin;
    case (r_state)
      IDLE: begin
        if (w_accept) begin
          w_state_nxt = FWD;
          w_cnt_nxt   = CNT_LOAD;
          w_a_nxt     = op_a;
          w_b_nxt     = op_b;
          w_cin_nxt   = op_cin;
        end
      end
      FWD: begin
        if (r_cnt == '0) w_state_nxt = CAP;
        else             w_cnt_nxt   = r_cnt - CNT_W'(1);
      end
      CAP: begin
        w_cap       = 1'b1;
        w_state_nxt = BWD;
        w_cnt_nxt   = CNT_LOAD;
      end
      BWD: begin
        if (r_cnt == '0) begin
          w_state_nxt = NUL;
          w_cnt_nxt   = CNT_LOAD;
        end else begin
          w_cnt_nxt = r_cnt - CNT_W'(1);
        end
      end
      NUL: begin
        if (r_cnt == '0) begin
          w_state_nxt = IDLE;
          w_done      = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt - CNT_W'(1);
        end
      end
      default: w_state_nxt = IDLE;
    endcase
    // Rails are registered, so their enables follow the phase being entered.
    w_fwd_en = (w_state_nxt == FWD) || (w_state_nxt == CAP);
    w_bwd_en = (w_state_nxt == BWD);
    w_b_en   = w_fwd_en || w_bwd_en;
  end

  dr_enc8 u_enc_af (.i_en(w_fwd_en), .i_d(w_a_nxt), .o_t_c(w_af_t), .o_n_c(w_af_n));
  dr_enc8 u_enc_ab (.i_en(w_bwd_en), .i_d(w_a_nxt), .o_t_c(w_ab_t), .o_n_c(w_ab_n));
  dr_enc8 u_enc_b  (.i_en(w_b_en),   .i_d(w_b_nxt), .o_t_c(w_b_t),  .o_n_c(w_b_n));

  assign w_c0f = dr_bit(w_fwd_en, w_cin_nxt);
  assign w_c0b = dr_bit(w_bwd_en, w_cin_nxt);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_a     <= '0;
      r_b     <= '0;
      r_cin   <= 1'b0;
      r_idle  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_a     <= w_a_nxt;
      r_b     <= w_b_nxt;
      r_cin   <= w_cin_nxt;
      r_idle  <= (w_state_nxt == IDLE);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_f      <= '0;
      a_not_f  <= '0;
      a_b      <= '0;
      a_not_b  <= '0;
      b        <= '0;
      b_not    <= '0;
      c0_f     <= 1'b0;
      c0_f_not <= 1'b0;
      c0_b     <= 1'b0;
      c0_not_b <= 1'b0;
    end else begin
      a_f      <= w_af_t;
      a_not_f  <= w_af_n;
      a_b      <= w_ab_t;
      a_not_b  <= w_ab_n;
      b        <= w_b_t;
      b_not    <= w_b_n;
      c0_f     <= w_c0f.t;
      c0_f_not <= w_c0f.n;
      c0_b     <= w_c0b.t;
      c0_not_b <= w_c0b.n;
    end
  end

  // Result register: loaded only on the capture cycle, so it is stable while res_valid holds.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_valid <= 1'b0;
      res_sum   <= '0;
      res_cout  <= 1'b0;
      res_err   <= 1'b0;
    end else begin
      if (w_cap) begin
        res_sum  <= s;
        res_cout <= c7;
        res_err  <= w_rail_err;
      end
      if (w_done)         res_valid <= 1'b1;
      else if (res_ready) res_valid <= 1'b0;
    end
  end

endmodule
